// File: rtl/pins_filt_if.sv
// Bus between a GPIO/alert register block (master) and one pins_filt bank (slave).
// The pad side travels in the same bundle so that one instance carries a whole bank.
interface pins_filt_if #(
  parameter int Width   = 1,
  parameter int FilterW = 4
);
  logic [Width-1:0]   drive_val_i;
  logic [Width-1:0]   drive_en_i;
  logic [Width-1:0]   od_en_i;
  logic [2*Width-1:0] pull_mode_i;
  logic [FilterW-1:0] filt_thresh_i;
  logic [Width-1:0]   evt_rise_en_i;
  logic [Width-1:0]   evt_fall_en_i;
  logic [Width-1:0]   evt_clr_i;
  logic [Width-1:0]   pad_i;
  logic [Width-1:0]   pad_o;
  logic [Width-1:0]   pad_oe_o;
  logic [Width-1:0]   pad_pu_o;
  logic [Width-1:0]   pad_pd_o;
  logic [Width-1:0]   sample_o;
  logic [Width-1:0]   rise_o;
  logic [Width-1:0]   fall_o;
  logic [Width-1:0]   evt_o;

  modport master (
    output drive_val_i, drive_en_i, od_en_i, pull_mode_i, filt_thresh_i,
           evt_rise_en_i, evt_fall_en_i, evt_clr_i, pad_i,
    input  pad_o, pad_oe_o, pad_pu_o, pad_pd_o, sample_o, rise_o, fall_o, evt_o
  );

  modport slave (
    input  drive_val_i, drive_en_i, od_en_i, pull_mode_i, filt_thresh_i,
           evt_rise_en_i, evt_fall_en_i, evt_clr_i, pad_i,
    output pad_o, pad_oe_o, pad_pu_o, pad_pd_o, sample_o, rise_o, fall_o, evt_o
  );
endinterface

// File: rtl/pins_filt.sv
// pins_filt: registered pad drive controls plus a synchronised, glitch-filtered
// receive path with edge pulses and maskable sticky event flags.
// All pins are independent; the filter threshold is shared by the bank.
module pins_filt #(
  parameter int Width      = 1,
  parameter int SyncStages = 2,
  parameter int FilterW    = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  pins_filt_if.slave bus
);

  // Synchroniser chain and a matching valid chain that tells when the last stage
  // holds a real pad sample rather than the reset value.
  logic [SyncStages-1:0][Width-1:0] sync_q;
  logic [SyncStages-1:0]            valid_q;
  logic [Width-1:0]                 s;
  logic                             s_valid;

  // Filter / edge / event state.
  logic                             primed_q;
  logic                             primed_d;
  logic [Width-1:0]                 sample_q;
  logic [Width-1:0]                 sample_d;
  logic [Width-1:0][FilterW-1:0]    cnt_q;
  logic [Width-1:0][FilterW-1:0]    cnt_d;
  logic [Width-1:0]                 rise_q;
  logic [Width-1:0]                 rise_d;
  logic [Width-1:0]                 fall_q;
  logic [Width-1:0]                 fall_d;
  logic [Width-1:0]                 evt_q;
  logic [Width-1:0]                 evt_d;

  // Drive path state.
  logic [Width-1:0]                 pad_q;
  logic [Width-1:0]                 pad_d;
  logic [Width-1:0]                 oe_q;
  logic [Width-1:0]                 oe_d;
  logic [Width-1:0]                 pu_q;
  logic [Width-1:0]                 pu_d;
  logic [Width-1:0]                 pd_q;
  logic [Width-1:0]                 pd_d;

  assign s       = sync_q[SyncStages-1];
  assign s_valid = valid_q[SyncStages-1];

  // Shift the raw pad input through the synchroniser and track sample validity.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {(SyncStages*Width){1'b0}};
      valid_q <= {SyncStages{1'b0}};
    end else begin
      sync_q[0] <= bus.pad_i;
      for (int k = 1; k < SyncStages; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      valid_q <= {valid_q[SyncStages-2:0], 1'b1};
    end
  end

  // Derive next pad drive, enable and pull controls; a pull never fights a driven pin.
  always_comb begin
    pad_d = {Width{1'b0}};
    oe_d  = {Width{1'b0}};
    pu_d  = {Width{1'b0}};
    pd_d  = {Width{1'b0}};
    for (int i = 0; i < Width; i++) begin
      if (bus.od_en_i[i]) begin
        oe_d[i]  = bus.drive_en_i[i] & ~bus.drive_val_i[i];
        pad_d[i] = 1'b0;
      end else begin
        oe_d[i]  = bus.drive_en_i[i];
        pad_d[i] = bus.drive_val_i[i];
      end
      case (bus.pull_mode_i[2*i +: 2])
        2'b01: begin
          pd_d[i] = ~oe_d[i];
          pu_d[i] = 1'b0;
        end
        2'b10: begin
          pu_d[i] = ~oe_d[i];
          pd_d[i] = 1'b0;
        end
        default: begin
          pu_d[i] = 1'b0;
          pd_d[i] = 1'b0;
        end
      endcase
    end
  end

  // Filter: count consecutive mismatching cycles and accept once the count reaches
  // the threshold; the first valid sample after reset is taken directly (priming).
  always_comb begin
    primed_d = primed_q | s_valid;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    rise_d   = {Width{1'b0}};
    fall_d   = {Width{1'b0}};
    for (int i = 0; i < Width; i++) begin
      if (!primed_q) begin
        cnt_d[i] = {FilterW{1'b0}};
        if (s_valid) begin
          sample_d[i] = s[i];
        end else begin
          sample_d[i] = sample_q[i];
        end
      end else if (s[i] == sample_q[i]) begin
        cnt_d[i] = {FilterW{1'b0}};
      end else if (cnt_q[i] >= bus.filt_thresh_i) begin
        sample_d[i] = s[i];
        cnt_d[i]    = {FilterW{1'b0}};
        rise_d[i]   = s[i];
        fall_d[i]   = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + {{(FilterW-1){1'b0}}, 1'b1};
      end
    end
    // A set in the same cycle as a clear wins.
    evt_d = (evt_q & ~bus.evt_clr_i)
          | (rise_d & bus.evt_rise_en_i)
          | (fall_d & bus.evt_fall_en_i);
  end

  // Register every output and the filter state; reset discards any pending count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      primed_q <= 1'b0;
      sample_q <= {Width{1'b0}};
      cnt_q    <= {(Width*FilterW){1'b0}};
      rise_q   <= {Width{1'b0}};
      fall_q   <= {Width{1'b0}};
      evt_q    <= {Width{1'b0}};
      pad_q    <= {Width{1'b0}};
      oe_q     <= {Width{1'b0}};
      pu_q     <= {Width{1'b0}};
      pd_q     <= {Width{1'b0}};
    end else begin
      primed_q <= primed_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      evt_q    <= evt_d;
      pad_q    <= pad_d;
      oe_q     <= oe_d;
      pu_q     <= pu_d;
      pd_q     <= pd_d;
    end
  end

  assign bus.pad_o    = pad_q;
  assign bus.pad_oe_o = oe_q;
  assign bus.pad_pu_o = pu_q;
  assign bus.pad_pd_o = pd_q;
  assign bus.sample_o = sample_q;
  assign bus.rise_o   = rise_q;
  assign bus.fall_o   = fall_q;
  assign bus.evt_o    = evt_q;

endmodule

// File: tb/tb_pins_filt.sv
// Directed bench for pins_filt (Width=4, SyncStages=2, FilterW=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pins_filt;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  pins_filt_if #(.Width(4), .FilterW(4)) bus ();

  pins_filt #(.Width(4), .SyncStages(2), .FilterW(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.pad_i         = 4'hF;
    bus.evt_rise_en_i = 4'hF;
    rst = 1'b1;
    step(2);
    checks++;
    if ({bus.pad_o, bus.pad_oe_o, bus.pad_pu_o, bus.pad_pd_o,
         bus.sample_o, bus.rise_o, bus.fall_o, bus.evt_o} !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got sample=%h evt=%h oe=%h expected all 0",
               bus.sample_o, bus.evt_o, bus.pad_oe_o);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      checks++;
      if (bus.rise_o !== 4'h0 || bus.evt_o !== 4'h0) begin
        failures++;
        $display("FAIL prime_no_rise cyc%0d: got rise=%h evt=%h expected 0 0", k, bus.rise_o, bus.evt_o);
      end
      if (k >= 3) begin
        checks++;
        if (bus.sample_o !== 4'hF) begin
          failures++;
          $display("FAIL prime_sample cyc%0d: got %h expected f", k, bus.sample_o);
        end
      end
    end
    // Bring all pins low again without recording events.
    bus.evt_rise_en_i = 4'h0;
    bus.pad_i = 4'h0;
    step(4);
    checks++;
    if (bus.sample_o !== 4'h0 || bus.evt_o !== 4'h0) begin
      failures++;
      $display("FAIL settle_low: got sample=%h evt=%h expected 0 0", bus.sample_o, bus.evt_o);
    end
  endtask

  task automatic test_filter();
    bus.filt_thresh_i = 4'd3;
    // 3-cycle glitch must be rejected.
    bus.pad_i[0] = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step(1);
      if (j == 3) bus.pad_i[0] = 1'b0;
      checks++;
      if (bus.sample_o[0] !== 1'b0 || bus.rise_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL glitch3 cyc%0d: got sample=%b rise=%b expected 0 0", j, bus.sample_o[0], bus.rise_o[0]);
      end
    end
    // 4-cycle pulse accepted at E+5, then the fall accepted 4 cycles later.
    bus.pad_i[0] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      logic exp_s;
      logic exp_r;
      logic exp_f;
      step(1);
      if (j == 4) bus.pad_i[0] = 1'b0;
      exp_s = (j >= 6 && j < 10);
      exp_r = (j == 6);
      exp_f = (j == 10);
      checks++;
      if (bus.sample_o[0] !== exp_s || bus.rise_o[0] !== exp_r || bus.fall_o[0] !== exp_f) begin
        failures++;
        $display("FAIL pulse4 cyc%0d: got s/r/f=%b%b%b expected %b%b%b", j,
                 bus.sample_o[0], bus.rise_o[0], bus.fall_o[0], exp_s, exp_r, exp_f);
      end
    end
  endtask

  task automatic test_drive();
    bus.od_en_i = 4'hF; bus.drive_en_i = 4'hF; bus.drive_val_i = 4'hF; bus.pull_mode_i = 8'hAA;
    step(1);
    checks++;
    if (bus.pad_oe_o !== 4'h0 || bus.pad_pu_o !== 4'hF || bus.pad_o !== 4'h0 || bus.pad_pd_o !== 4'h0) begin
      failures++;
      $display("FAIL od_release: got oe=%h pu=%h o=%h pd=%h expected 0 f 0 0",
               bus.pad_oe_o, bus.pad_pu_o, bus.pad_o, bus.pad_pd_o);
    end
    bus.drive_val_i = 4'h0;
    step(1);
    checks++;
    if (bus.pad_oe_o !== 4'hF || bus.pad_pu_o !== 4'h0 || bus.pad_o !== 4'h0) begin
      failures++;
      $display("FAIL od_pull_low: got oe=%h pu=%h o=%h expected f 0 0", bus.pad_oe_o, bus.pad_pu_o, bus.pad_o);
    end
    bus.od_en_i = 4'h0; bus.drive_en_i = 4'h3; bus.drive_val_i = 4'h5; bus.pull_mode_i = 8'h55;
    step(1);
    checks++;
    if (bus.pad_oe_o !== 4'h3 || bus.pad_o !== 4'h5 || bus.pad_pd_o !== 4'hC || bus.pad_pu_o !== 4'h0) begin
      failures++;
      $display("FAIL push_pull: got oe=%h o=%h pd=%h pu=%h expected 3 5 c 0",
               bus.pad_oe_o, bus.pad_o, bus.pad_pd_o, bus.pad_pu_o);
    end
    bus.drive_en_i = 4'h0; bus.pull_mode_i = 8'hFF;
    step(1);
    checks++;
    if (bus.pad_oe_o !== 4'h0 || bus.pad_pd_o !== 4'h0 || bus.pad_pu_o !== 4'h0) begin
      failures++;
      $display("FAIL pull_mode11: got oe=%h pd=%h pu=%h expected 0 0 0", bus.pad_oe_o, bus.pad_pd_o, bus.pad_pu_o);
    end
  endtask

  task automatic test_events();
    bus.filt_thresh_i = 4'd0;
    bus.pad_i[2] = 1'b1;
    step(3);
    checks++;
    if (bus.sample_o[2] !== 1'b1 || bus.evt_o !== 4'h0) begin
      failures++;
      $display("FAIL evt_rise_masked: got sample2=%b evt=%h expected 1 0", bus.sample_o[2], bus.evt_o);
    end
    bus.evt_fall_en_i = 4'h4;
    bus.pad_i[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] exp_e;
      step(1);
      exp_e = (k >= 3) ? 4'h4 : 4'h0;
      checks++;
      if (bus.evt_o !== exp_e || bus.fall_o[2] !== (k == 3)) begin
        failures++;
        $display("FAIL evt_fall cyc%0d: got evt=%h fall2=%b expected %h %b", k, bus.evt_o, bus.fall_o[2], exp_e, k == 3);
      end
    end
    bus.pad_i[2] = 1'b1;
    step(3);
    bus.pad_i[2] = 1'b0;
    step(2);
    bus.evt_clr_i = 4'h4;
    step(1);
    bus.evt_clr_i = 4'h0;
    checks++;
    if (bus.fall_o[2] !== 1'b1 || bus.evt_o !== 4'h4) begin
      failures++;
      $display("FAIL set_beats_clear: got fall2=%b evt=%h expected 1 4", bus.fall_o[2], bus.evt_o);
    end
    bus.evt_clr_i = 4'h4;
    step(1);
    bus.evt_clr_i = 4'h0;
    checks++;
    if (bus.evt_o !== 4'h0) begin
      failures++;
      $display("FAIL evt_clear: got %h expected 0", bus.evt_o);
    end
  endtask

  task automatic test_thresh_change();
    bus.filt_thresh_i = 4'd10;
    bus.evt_rise_en_i = 4'h2;
    bus.pad_i[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      checks++;
      if (bus.sample_o[1] !== 1'b0) begin
        failures++;
        $display("FAIL thr_hold cyc%0d: got %b expected 0", k, bus.sample_o[1]);
      end
    end
    bus.filt_thresh_i = 4'd2;
    step(1);
    checks++;
    if (bus.sample_o[1] !== 1'b1 || bus.rise_o !== 4'h2 || bus.evt_o !== 4'h2) begin
      failures++;
      $display("FAIL thr_lowered: got sample1=%b rise=%h evt=%h expected 1 2 2",
               bus.sample_o[1], bus.rise_o, bus.evt_o);
    end
  endtask

  task automatic test_mid_reset();
    bus.filt_thresh_i = 4'd0;
    bus.evt_rise_en_i = 4'h8;
    bus.od_en_i = 4'h0; bus.drive_en_i = 4'hF; bus.drive_val_i = 4'hF; bus.pull_mode_i = 8'h00;
    bus.pad_i = 4'hA;
    step(3);
    checks++;
    if (bus.evt_o !== 4'hA || bus.pad_o !== 4'hF) begin
      failures++;
      $display("FAIL pre_reset_state: got evt=%h pad_o=%h expected a f", bus.evt_o, bus.pad_o);
    end
    bus.filt_thresh_i = 4'd15;
    bus.pad_i = 4'hB;
    step(7);
    checks++;
    if (bus.sample_o !== 4'hA) begin
      failures++;
      $display("FAIL mid_count: got %h expected a", bus.sample_o);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if ({bus.pad_o, bus.pad_oe_o, bus.pad_pu_o, bus.pad_pd_o,
         bus.sample_o, bus.rise_o, bus.fall_o, bus.evt_o} !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got o=%h oe=%h sample=%h evt=%h expected all 0",
               bus.pad_o, bus.pad_oe_o, bus.sample_o, bus.evt_o);
    end
    rst = 1'b0;
    bus.evt_rise_en_i = 4'hF;
    bus.evt_fall_en_i = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] exp_s;
      step(1);
      exp_s = (k >= 3) ? 4'hB : 4'h0;
      checks++;
      if (bus.sample_o !== exp_s || bus.rise_o !== 4'h0 || bus.fall_o !== 4'h0 || bus.evt_o !== 4'h0) begin
        failures++;
        $display("FAIL reprime cyc%0d: got s=%h r=%h f=%h e=%h expected %h 0 0 0",
                 k, bus.sample_o, bus.rise_o, bus.fall_o, bus.evt_o, exp_s);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.drive_val_i   = 4'h0;
    bus.drive_en_i    = 4'h0;
    bus.od_en_i       = 4'h0;
    bus.pull_mode_i   = 8'h00;
    bus.filt_thresh_i = 4'd0;
    bus.evt_rise_en_i = 4'h0;
    bus.evt_fall_en_i = 4'h0;
    bus.evt_clr_i     = 4'h0;
    bus.pad_i         = 4'h0;
    #1;
    test_reset();
    test_filter();
    test_drive();
    test_events();
    test_thresh_change();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
